// File: rtl/fir_serial_mac_if.sv
// fir_serial_mac_if: sample-in, coefficient-write and sample-out bus of the FIR core.
// slave = FIR core side, master = producer/consumer side.
interface fir_serial_mac_if #(
  parameter int DATA_W = 24,
  parameter int COEF_W = 16,
  parameter int OUT_W  = 24,
  parameter int TAPS   = 16
);
  localparam int AW = $clog2(TAPS);

  logic signed [DATA_W-1:0] iv_din;
  logic                     i_din_valid;
  logic                     o_ready;
  logic                     i_coef_we;
  logic        [AW-1:0]     iv_coef_addr;
  logic signed [COEF_W-1:0] iv_coef_data;
  logic signed [OUT_W-1:0]  ov_dout;
  logic                     o_dout_valid;
  logic                     i_dout_ready;

  modport slave (
    input  iv_din, i_din_valid,
    output o_ready,
    input  i_coef_we, iv_coef_addr, iv_coef_data,
    output ov_dout, o_dout_valid,
    input  i_dout_ready
  );

  modport master (
    output iv_din, i_din_valid,
    input  o_ready,
    output i_coef_we, iv_coef_addr, iv_coef_data,
    input  ov_dout, o_dout_valid,
    output i_dout_ready
  );
endinterface

// File: rtl/fir_serial_mac.sv
// fir_serial_mac: single-multiplier time-multiplexed FIR, one MAC per clock.
// Ports: i_clk, i_rst (sync, high), i_en (clock enable), bus (fir_serial_mac_if.slave:
//   sample in + o_ready, coefficient write, sample out valid/ready).
// Optional: define FIR_ROUND_EN for round-half-up before the output shift.
module fir_serial_mac #(
  parameter int DATA_W = 24,
  parameter int COEF_W = 16,
  parameter int TAPS   = 16,
  parameter int OUT_W  = 24,
  parameter int SHIFT  = 15
) (
  input logic              i_clk,
  input logic              i_rst,
  input logic              i_en,
  fir_serial_mac_if.slave  bus
);
  localparam int AW    = $clog2(TAPS);
  localparam int PW    = DATA_W + COEF_W;
  localparam int ACC_W = DATA_W + COEF_W + $clog2(TAPS);
  // One extra bit so the rounding add can never wrap.
  localparam int SW    = ACC_W + 1;

  localparam logic [AW-1:0] LAST = AW'(TAPS - 1);

  localparam logic signed [SW-1:0] OMAX =
    {{(SW-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [SW-1:0] OMIN =
    {{(SW-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

`ifdef FIR_ROUND_EN
  // 2^(SHIFT-1), or zero when SHIFT==0.
  localparam logic signed [SW-1:0] RND =
    (SW'(1) << SHIFT) >> 1;
`endif

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    MAC    = 2'd1,
    SCALE  = 2'd2,
    OUTPUT = 2'd3
  } state_t;

  state_t                   state_q, state_d;
  logic signed [ACC_W-1:0]  acc_q, acc_d;
  logic        [AW-1:0]     tap_q, tap_d;
  logic        [AW-1:0]     rd_q, rd_d;
  logic        [AW-1:0]     wr_q, wr_d;
  logic signed [OUT_W-1:0]  dout_q, dout_d;
  logic                     dval_q, dval_d;

  logic signed [DATA_W-1:0] dline_q [TAPS];
  logic signed [COEF_W-1:0] coef_q  [TAPS];

  logic                     accept;
  logic                     coef_wr;
  logic signed [PW-1:0]     prod;
  logic signed [SW-1:0]     rsum;
  logic signed [SW-1:0]     shifted;
  logic signed [OUT_W-1:0]  sat;

  assign accept  = (state_q == IDLE) && bus.i_din_valid && i_en;
  assign coef_wr = (state_q == IDLE) && bus.i_coef_we && i_en
                 && ({1'b0, bus.iv_coef_addr} < (AW+1)'(TAPS));

  // rd_q walks backwards from the newest sample: buf[(wr_ptr-k) mod TAPS].
  assign prod = coef_q[tap_q] * dline_q[rd_q];

`ifdef FIR_ROUND_EN
  assign rsum = {acc_q[ACC_W-1], acc_q} + RND;
`else
  assign rsum = {acc_q[ACC_W-1], acc_q};
`endif

  assign shifted = rsum >>> SHIFT;

  always_comb begin
    sat = shifted[OUT_W-1:0];
    unique case (1'b1)
      (shifted > OMAX): sat = {1'b0, {(OUT_W-1){1'b1}}};
      (shifted < OMIN): sat = {1'b1, {(OUT_W-1){1'b0}}};
      default:          sat = shifted[OUT_W-1:0];
    endcase
  end

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    tap_d   = tap_q;
    rd_d    = rd_q;
    wr_d    = wr_q;
    dout_d  = dout_q;
    dval_d  = dval_q;
    case (state_q)
      IDLE: begin
        if (bus.i_din_valid) begin
          acc_d   = '0;
          tap_d   = '0;
          rd_d    = wr_q;
          state_d = MAC;
        end
      end
      MAC: begin
        acc_d = acc_q + {{(ACC_W-PW){prod[PW-1]}}, prod};
        tap_d = tap_q + AW'(1);
        rd_d  = (rd_q == '0) ? LAST : rd_q - AW'(1);
        if (tap_q == LAST) begin
          state_d = SCALE;
        end
      end
      SCALE: begin
        dout_d  = sat;
        dval_d  = 1'b1;
        state_d = OUTPUT;
      end
      OUTPUT: begin
        if (bus.i_dout_ready) begin
          dval_d  = 1'b0;
          wr_d    = (wr_q == LAST) ? '0 : wr_q + AW'(1);
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= IDLE;
      acc_q   <= '0;
      tap_q   <= '0;
      rd_q    <= '0;
      wr_q    <= '0;
      dout_q  <= '0;
      dval_q  <= 1'b0;
      for (int i = 0; i < TAPS; i++) begin
        dline_q[i] <= '0;
        coef_q[i]  <= '0;
      end
    end else if (i_en) begin
      state_q <= state_d;
      acc_q   <= acc_d;
      tap_q   <= tap_d;
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      dout_q  <= dout_d;
      dval_q  <= dval_d;
      if (accept) begin
        dline_q[wr_q] <= bus.iv_din;
      end
      if (coef_wr) begin
        coef_q[bus.iv_coef_addr] <= bus.iv_coef_data;
      end
    end
  end

  assign bus.o_ready      = (state_q == IDLE);
  assign bus.ov_dout      = dout_q;
  assign bus.o_dout_valid = dval_q;

endmodule

// File: doc/fir_serial_mac.md
Name: fir_serial_mac

Overview:
Single-multiplier, time-multiplexed FIR filter core that consumes parallel samples from the serial-to-parallel deserializer and produces one filtered sample per accepted input. It stores the last TAPS samples in a circular delay line and holds TAPS programmable coefficients. It performs one multiply-accumulate per clock, then scales, optionally rounds, saturates, and presents the result with a valid/ready handshake to the downstream consumer.

Parameters:
DATA_W, 24, input sample width; signed two's complement.
COEF_W, 16, coefficient width; signed two's complement.
TAPS, 16, number of taps; legal range is 2 or more, and a power of two is not required.
OUT_W, 24, output sample width; signed.
SHIFT, 15, arithmetic right shift applied to the accumulator before saturation; legal range is 0 to ACC_W-1.
ACC_W (localparam), DATA_W+COEF_W+$clog2(TAPS), accumulator width.

Ports:
i_clk  in  1  clock; all logic is on the rising edge.
i_rst  in  1  synchronous, active-high reset.
i_en  in  1  clock enable; when low, all state, registers and outputs hold.
iv_din  in  DATA_W  input sample.
i_din_valid  in  1  input sample valid.
o_ready  out  1  core can accept a sample; this drives the deserializer's i_ready.
i_coef_we  in  1  coefficient write strobe.
iv_coef_addr  in  $clog2(TAPS)  coefficient index k.
iv_coef_data  in  COEF_W  coefficient value.
ov_dout  out  OUT_W  filtered sample.
o_dout_valid  out  1  ov_dout is valid.
i_dout_ready  in  1  downstream accepts ov_dout.

Behaviour:
- Reset values:
  - state=IDLE, so o_ready=1.
  - o_dout_valid=0, ov_dout=0.
  - accumulator=0, tap index=0, write pointer wr_ptr=0.
  - All delay-line entries and all coefficients are cleared to 0.
- Reset mid-operation aborts any computation; a pending output is discarded.
- o_ready is a pure decode of the state register: it is 1 only in IDLE. It does not depend on i_en.
- Sample acceptance occurs when state=IDLE, i_din_valid=1 and i_en=1.
- States:
  - IDLE: on acceptance, write buf[wr_ptr]<=iv_din, clear acc and tap index, then go to MAC.
  - MAC: runs exactly TAPS cycles. In cycle k (k=0..TAPS-1): acc += coef[k] * buf[(wr_ptr-k) mod TAPS], with signed full-precision arithmetic into ACC_W. After k=TAPS-1, go to SCALE.
  - SCALE: y = acc >>> SHIFT (arithmetic shift). Saturate y to [-2^(OUT_W-1), 2^(OUT_W-1)-1]. Register y into ov_dout, set o_dout_valid<=1, then go to OUTPUT.
  - OUTPUT: hold ov_dout and o_dout_valid. When i_dout_ready=1 and i_en=1: clear o_dout_valid, advance wr_ptr (wrapping TAPS-1 to 0), then go to IDLE.
  - Any illegal state encoding goes to IDLE.
- Latency: if acceptance happens at edge E0, o_dout_valid rises at edge E(TAPS+1). Minimum sample period is TAPS+3 cycles.
- wr_ptr modulo arithmetic uses an explicit compare and wrap, not bit truncation.
- Coefficient writes take effect only when state=IDLE and i_en=1: coef[iv_coef_addr]<=iv_coef_data.
  - Writes in any other state are ignored.
  - A write in the same cycle as sample acceptance takes effect and is used for that sample.
  - An address >= TAPS is ignored.
- Backpressure: while in OUTPUT, no new sample is accepted (o_ready=0). The upstream stage holds its data.
- i_en low in any state freezes the machine. It also suspends acceptance, coefficient writes and output handshake completion.

Optional Feature:
FIR_ROUND_EN.
- Defined: in SCALE, when SHIFT>0, add 2^(SHIFT-1) to acc before the shift (round half up), then saturate. The add must not overflow, because ACC_W has at least one guard bit.
- Undefined: plain truncation via arithmetic shift.
- Latency is identical in both builds.

Test Plan:
- Gain: SHIFT=15 default. Write coef[0]=16384, others 0. Input 1000 -> ov_dout=500 with o_dout_valid at exactly E0+17. Input -1000 -> -500.
- Impulse response: SHIFT=0, coef[k]=k+1. Input 1 followed by 19 zeros -> outputs 1,2,...,16, then 0,0,0,0. This checks circular delay-line ordering and wr_ptr wrap.
- Saturation: SHIFT=0, coef[0]=32767. Input 8388607 -> 8388607. Input -8388608 -> -8388608 (clamped; no wrap).
- Rounding: SHIFT=15, coef[0]=1, input 16384 -> 1 with FIR_ROUND_EN, 0 without. Input 16383 -> 0 in both builds.
- Backpressure and enable: hold i_dout_ready=0 for 10 cycles -> ov_dout stable and o_ready=0 throughout; the next sample is accepted only after the handshake. Deassert i_en mid-MAC for 5 cycles -> result is unchanged and delayed by 5 cycles.
- Reset mid-MAC: assert i_rst at MAC cycle 7 -> next edge shows o_ready=1, o_dout_valid=0. A subsequent sample with coef[0]=16384 reloaded -> correct output, and history is all zeros.
